// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer types for rename, register_status and commit
package rob_pkg;

    localparam int ROB_MSB   = 2;
    localparam int REG_MSB   = 4;
    localparam int DATA_MSB  = 31;
    localparam int ROB_DEPTH = 8;

    typedef logic [ROB_MSB:0] rob_idx_t;
    typedef logic [REG_MSB:0] reg_idx_t;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic                reg_write;
        logic                mispredict;
        reg_idx_t            dest_reg;
        logic [DATA_MSB:0]   value;
    } rob_entry_t;

endpackage

// File: rtl/rob_pointer.sv
// rtl/rob_pointer.sv - head/tail/count register set with full/empty flags
module rob_pointer #(
    parameter int ROB = 2
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           inc_head,
    input  logic           inc_tail,
    input  logic           clear,
    output logic [ROB:0]   head,
    output logic [ROB:0]   tail,
    output logic [ROB+1:0] count,
    output logic           full,
    output logic           empty
);

    localparam logic [ROB+1:0] FULL_CNT = {1'b1, {(ROB+1){1'b0}}};

    logic [ROB:0]   head_q, head_d;
    logic [ROB:0]   tail_q, tail_d;
    logic [ROB+1:0] count_q, count_d;

    // Next-state pointers; indices wrap naturally, clear wins over any advance.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (inc_head) head_d = head_q + 1'b1;
        if (inc_tail) tail_d = tail_q + 1'b1;
        if (inc_tail && !inc_head) count_d = count_q + 1'b1;
        if (inc_head && !inc_tail) count_d = count_q - 1'b1;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign tail  = tail_q;
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 8-entry in-order retirement queue between rename and commit
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB   = ROB_MSB,
    parameter int REG   = REG_MSB,
    parameter int WIDTH = DATA_MSB
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           allocReq,
    input  logic           allocRegWrite,
    input  logic [REG:0]   allocDestReg,
    output logic [ROB:0]   allocROB,
    output logic           full,
    output logic           empty,
    input  logic           cdbValid,
    input  logic [ROB:0]   cdbROB,
    input  logic [WIDTH:0] cdbValue,
    input  logic           cdbMispredict,
    input  logic [ROB:0]   rob1,
    input  logic [ROB:0]   rob2,
    output logic           rdReady1,
    output logic           rdReady2,
    output logic [WIDTH:0] rdValue1,
    output logic [WIDTH:0] rdValue2,
    output logic           commitFire,
    output logic           validCommit,
    output logic [REG:0]   regCommit,
    output logic [ROB:0]   commitROB,
    output logic [WIDTH:0] commitValue,
    output logic           flush
);

    localparam int DEPTH = 2 ** (ROB + 1);

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];

    logic [ROB:0]   head;
    logic [ROB:0]   tail;
    logic [ROB+1:0] count;
    rob_entry_t     head_entry;
    logic           alloc_fire;

    rob_pointer #(.ROB(ROB)) u_ptr (
        .clk      (clk),
        .resetN   (resetN),
        .inc_head (commitFire),
        .inc_tail (alloc_fire),
        .clear    (flush),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign head_entry  = entries_q[head];
    assign commitFire  = head_entry.valid & head_entry.ready;
    assign flush       = commitFire & head_entry.mispredict;
    assign alloc_fire  = allocReq & ~full & ~flush;

    assign allocROB    = tail;
    assign commitROB   = head;
    assign validCommit = commitFire & head_entry.reg_write;
    assign regCommit   = head_entry.dest_reg;
    assign commitValue = head_entry.value;

    // Entry updates: complete, retire, allocate; a flush drops every pending write and invalidates all.
    always_comb begin
        entries_d = entries_q;
        if (cdbValid && entries_q[cdbROB].valid) begin
            entries_d[cdbROB].ready      = 1'b1;
            entries_d[cdbROB].value      = cdbValue;
            entries_d[cdbROB].mispredict = cdbMispredict;
        end
        if (commitFire) entries_d[head].valid = 1'b0;
        if (alloc_fire) begin
            entries_d[tail] = '{valid: 1'b1, ready: 1'b0, reg_write: allocRegWrite,
                                mispredict: 1'b0, dest_reg: allocDestReg, value: '0};
        end
        if (flush) begin
            entries_d = entries_q;
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
        end
    end

    // Entry array in flops so valid bits reset asynchronously.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) entries_q <= '{default: '0};
        else         entries_q <= entries_d;
    end

    // Operand read ports with same-cycle CDB forwarding.
    always_comb begin
        rdReady1 = entries_q[rob1].ready;
        rdValue1 = entries_q[rob1].value;
        rdReady2 = entries_q[rob2].ready;
        rdValue2 = entries_q[rob2].value;
        if (cdbValid && cdbROB == rob1) begin
            rdReady1 = 1'b1;
            rdValue1 = cdbValue;
        end
        if (cdbValid && cdbROB == rob2) begin
            rdReady2 = 1'b1;
            rdValue2 = cdbValue;
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- In-order retirement queue between rename and commit: 8 entries (2^(ROB+1)), circular.
- Rename stage allocates one entry per cycle and passes the returned index to register_status as `destROB`.
- Execution units complete entries over the CDB. The oldest ready entry retires each cycle, driving `validCommit`/`regCommit`/`commitROB` into register_status.
- A retiring mispredicted branch flushes all entries.

## Interface

Parameters:
- `ROB`, 2: ROB index MSB; depth = 2^(ROB+1) = 8.
- `REG`, 4: register index MSB (32 registers).
- `WIDTH`, 31: data MSB.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `resetN`, in, 1: asynchronous, active-low reset.
- `allocReq`, in, 1: rename-stage instruction requests an entry.
- `allocRegWrite`, in, 1: instruction writes a destination register.
- `allocDestReg`, in, REG+1: destination register.
- `allocROB`, out, ROB+1: index granted (current tail).
- `full`, out, 1: no free entry.
- `empty`, out, 1: no valid entry.
- `cdbValid`, in, 1: completion broadcast.
- `cdbROB`, in, ROB+1: completing entry.
- `cdbValue`, in, WIDTH+1: result.
- `cdbMispredict`, in, 1: completing branch was mispredicted.
- `rob1`, `rob2`, in, ROB+1: operand producer entries from register_status.
- `rdReady1`, `rdReady2`, out, 1: producer result available.
- `rdValue1`, `rdValue2`, out, WIDTH+1: producer result.
- `commitFire`, out, 1: head entry retires this cycle.
- `validCommit`, out, 1: retiring entry writes a register (`commitFire & regWrite`).
- `regCommit`, out, REG+1: retiring destination register.
- `commitROB`, out, ROB+1: retiring index (current head).
- `commitValue`, out, WIDTH+1: retiring result.
- `flush`, out, 1: retiring entry was mispredicted; pipeline must squash.

## Operation

Each entry holds `{valid, ready, regWrite, mispredict, destReg, value}`. State is `head`, `tail` (ROB+1 bits, wrap naturally) and `count` (ROB+2 bits).

- **Allocate:** `allocReq & ~full & ~flush` writes entry[tail] = {1, 0, allocRegWrite, 0, allocDestReg, 0}, then tail++ and count++.
- **Complete:** `cdbValid & entry[cdbROB].valid` sets ready, value and mispredict.
- CDB to an invalid entry is ignored.
- **Retire:** `commitFire = entry[head].valid & entry[head].ready`. On fire, clear entry[head].valid, then head++ and count--.
- Commit outputs come from entry[head] regardless of fire. `validCommit` is gated by fire and by regWrite.
- **Flush:** `flush = commitFire & entry[head].mispredict`. On the next edge, all valid bits clear and head = tail = count = 0.
  - Any allocation in the flush cycle is discarded.
  - Any CDB write in the flush cycle is discarded.
- **Operand read (combinational):**
  - If `cdbValid & cdbROB==robN`: `rdReadyN=1`, `rdValueN=cdbValue`.
  - Otherwise ready/value come from entry[robN].
- **Flags:** `full = (count==8)`, `empty = (count==0)`.

## Timing

- **Reset** (asynchronous, resetN low):
  - head = tail = count = 0; all entries invalid.
  - Outputs: `full=0`, `empty=1`, `allocROB=0`, `commitFire=0`, `validCommit=0`, `flush=0`, `commitROB=0`.
  - Reset takes priority over everything, including mid-flush.
- **Allocate:** `allocROB` is valid combinationally in the request cycle. The entry is visible one cycle later.
- **Complete:** a CDB write is visible to retire one cycle later. An entry completing in the cycle it is at head retires on the next cycle, not the same one.
- **Operand read bypass:** same-cycle CDB forwarding on the read ports.
- **Full with simultaneous retire:** allocation is refused (full is based on registered count). The slot frees next cycle.
- **Simultaneous allocate and retire:** count is unchanged; head and tail both advance.
- **Wrap-around:** index 7 is followed by 0, with no bubble.
- **Throughput:** one allocate and one retire per cycle.

## Structure

- Package `rob_pkg`:
  - `rob_entry_t` struct.
  - `ROB_DEPTH = 8`.
  - `rob_idx_t` and `reg_idx_t` typedefs.
  - Shared with rename and register_status.
- Sub-module `rob_pointer`: head/tail/count register set with inc-head, inc-tail and clear inputs, producing `full`/`empty`.
- Entry array lives in flip-flops. It needs async reset of the valid bits and 3 combinational read ports (head, rob1, rob2), so it does not map to MLAB.

## Test plan

- Reset, then 8 allocs (reg 1..8, write=1) → `allocROB` 0..7, `full=1` after 8th; 9th request refused, tail stays 0.
- CDB entry 2 value 0xAB while head=0 → no retire. Then CDB 0 and 1 → retires 0,1,2 on consecutive cycles, `commitValue` 0xAB on the third.
- `rob1=3` with `cdbValid`, `cdbROB=3`, `cdbValue=0x55` in the same cycle → `rdReady1=1`, `rdValue1=0x55`.
- Full ROB with head ready plus an allocReq in the same cycle → alloc refused. Next cycle alloc gets index 0 (wrap); count stays 8.
- Entry 0 completes with mispredict, entries 1..3 valid → `flush=1` while entry 0 retires. Next cycle: `empty=1`, head=tail=0; allocReq in the flush cycle discarded.
- Store entry (regWrite=0) retires → `commitFire=1`, `validCommit=0`.
